rr_arb_mux4: RTL and testbench

- Round-robin arbiter and output register for four 32-bit requesters. It sits directly upstream of a consumer that takes one word per cycle.
- Picks one of four valid sources each cycle and generates the 2-bit select for a 32-bit 4:1 mux datapath. The selected word is registered with a valid/ready handshake toward the consumer.
- Gives fair, starvation-free access to one shared 32-bit bus.

---
 rtl/rr_arb_mux4_pkg.sv | 41 ++++
 rtl/rr_arb_mux4_mux.sv | 26 ++
 rtl/rr_arb_mux4.sv | 97 +++++++++
 tb/tb_rr_arb_mux4.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux4_pkg.sv
// Shared definitions for the four-source round-robin arbiter: source counts,
// select encodings, output-register states and the rotating-priority scan.
package rr_arb_mux4_pkg;

    localparam int SRC_N = 4;
    localparam int SRC_W = 2;

    localparam logic [SRC_W-1:0] SEL_IN1 = 2'd0;
    localparam logic [SRC_W-1:0] SEL_IN2 = 2'd1;
    localparam logic [SRC_W-1:0] SEL_IN3 = 2'd2;
    localparam logic [SRC_W-1:0] SEL_IN4 = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SRC_W-1:0] idx;
    } scan_t;

    // Walks the candidates from the farthest offset back to ptr itself, so the
    // nearest valid source at or after ptr is the last one written and wins.
    function automatic scan_t rr_scan(input logic [SRC_N-1:0] valid,
                                      input logic [SRC_W-1:0] ptr);
        scan_t            res;
        logic [SRC_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = ptr;
        for (int k = SRC_N - 1; k >= 0; k--) begin
            cand = ptr + SRC_W'(k);
            if (valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb_mux4_mux.sv
// Plain 4:1 word multiplexer for the shared data bus.
module rr_arb_mux4_mux
    import rr_arb_mux4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [SRC_W-1:0] sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    output logic [WIDTH-1:0] word
);

    always_comb begin
        word = in1;
        case (sel)
            SEL_IN1: word = in1;
            SEL_IN2: word = in2;
            SEL_IN3: word = in3;
            SEL_IN4: word = in4;
            default: word = in1;
        endcase
    end

endmodule

// File: rtl/rr_arb_mux4.sv
// Round-robin arbiter over four word sources feeding a one-entry output
// register with a valid/ready handshake, plus saturating per-source grant counters.
module rr_arb_mux4
    import rr_arb_mux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SRC_N-1:0]       in_valid,
    output logic [SRC_N-1:0]       in_ready,
    input  logic [WIDTH-1:0]       in1,
    input  logic [WIDTH-1:0]       in2,
    input  logic [WIDTH-1:0]       in3,
    input  logic [WIDTH-1:0]       in4,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SRC_W-1:0]       sel,
    output logic [SRC_N*CNT_W-1:0] grant_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] rr_ptr;
    scan_t            scan;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] mux_word;
    logic [CNT_W-1:0] cnt [SRC_N];

    assign out_valid = (state == ST_FULL);

    // The register may accept a new word when empty or being drained this cycle;
    // reset masks the handshake so nothing is consumed while it is held.
    always_comb begin
        scan      = rr_scan(in_valid, rr_ptr);
        load      = ~out_valid | out_ready;
        take      = load & scan.found & ~reset;
        sel       = reset ? '0 : scan.idx;
        in_ready  = '0;
        state_nxt = state;
        if (take) begin
            in_ready[scan.idx] = 1'b1;
        end
        if (load) begin
            state_nxt = scan.found ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    rr_arb_mux4_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel  (sel),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .in4  (in4),
        .word (mux_word)
    );

    // Data, source tag and pointer only move on an accepted word, so an
    // empty cycle leaves the last word visible on out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (take) begin
            out_data <= mux_word;
            out_src  <= scan.idx;
            rr_ptr   <= scan.idx + 1'b1;
        end
    end

    for (genvar i = 0; i < SRC_N; i++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (take && (scan.idx == SRC_W'(i)) && (cnt[i] != '1)) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Self-checking bench for rr_arb_mux4: directed scenarios plus random traffic
// compared cycle by cycle against a rotating-priority reference model.
module tb_rr_arb_mux4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  inValid;
    logic [31:0] in1, in2, in3, in4;
    logic        outReady;

    logic [3:0]  inReady;
    logic [31:0] outData;
    logic [1:0]  outSrc;
    logic        outValid;
    logic [1:0]  sel;
    logic [63:0] grantCnt;

    logic [3:0]  satInReady;
    logic [31:0] satOutData;
    logic [1:0]  satOutSrc;
    logic        satOutValid;
    logic [1:0]  satSel;
    logic [7:0]  satGrantCnt;

    int errors = 0;
    int checks = 0;

    bit          mValid;
    logic [31:0] mData;
    int          mSrc;
    int          mPtr;
    int          mCnt [4];
    int          satExp [6] = '{1, 2, 3, 3, 3, 3};

    always #5 clk = ~clk;

    rr_arb_mux4 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .out_data  (outData),
        .out_src   (outSrc),
        .out_valid (outValid),
        .out_ready (outReady),
        .sel       (sel),
        .grant_cnt (grantCnt)
    );

    rr_arb_mux4 #(.WIDTH(32), .CNT_W(2)) dutSat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (satInReady),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .out_data  (satOutData),
        .out_src   (satOutSrc),
        .out_valid (satOutValid),
        .out_ready (outReady),
        .sel       (satSel),
        .grant_cnt (satGrantCnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] wordOf(input int w);
        case (w)
            0:       return in1;
            1:       return in2;
            2:       return in3;
            default: return in4;
        endcase
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mData  = '0;
        mSrc   = 0;
        mPtr   = 0;
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
    endtask

    function automatic logic [63:0] expCounts();
        return {16'(mCnt[3]), 16'(mCnt[2]), 16'(mCnt[1]), 16'(mCnt[0])};
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic applyStimulus(input logic [3:0] v, input logic rdy);
        int         w;
        bit         load;
        logic [3:0] expReady;
        inValid  = v;
        outReady = rdy;
        #1;
        w        = pickWinner(inValid, mPtr);
        load     = !mValid || outReady;
        expReady = '0;
        if (load && w >= 0) expReady[w] = 1'b1;
        checkOutput("in_ready", 64'(inReady), 64'(expReady));
        checkOutput("sel", 64'(sel), 64'((w >= 0) ? w : mPtr));
        @(posedge clk);
        if (load) begin
            if (w >= 0) begin
                mData  = wordOf(w);
                mSrc   = w;
                mValid = 1'b1;
                mPtr   = (w + 1) % 4;
                if (mCnt[w] < 65535) mCnt[w]++;
            end else begin
                mValid = 1'b0;
            end
        end
        #1;
        checkOutput("out_valid", 64'(outValid), 64'(mValid));
        checkOutput("out_data", 64'(outData), 64'(mData));
        checkOutput("out_src", 64'(outSrc), 64'(mSrc));
        checkOutput("grant_cnt", grantCnt, expCounts());
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases after the next edge.
    task automatic pulseReset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_out_data", 64'(outData), 64'd0);
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkOutput("rst_sel", 64'(sel), 64'd0);
        checkOutput("rst_grant_cnt", grantCnt, 64'd0);
        checkOutput("rst_sat_cnt", 64'(satGrantCnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = '0;
        outReady = 1'b0;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset while all sources request");
        in1 = 32'h11111111; in2 = 32'h22222222; in3 = 32'h33333333; in4 = 32'h44444444;
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1);
        inValid = 4'b1111;
        pulseReset();

        $display("[TB] all sources busy");
        for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b1);
        checkOutput("cnt_after8", grantCnt, {4{16'd2}});

        $display("[TB] sparse request");
        for (int i = 0; i < 3; i++) applyStimulus(4'b1010, 1'b1);

        $display("[TB] backpressure");
        in1 = 32'hAAAA5555;
        applyStimulus(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100, 1'b0);
            checkOutput("hold_data", 64'(outData), 64'h00000000AAAA5555);
        end
        applyStimulus(4'b0100, 1'b1);
        checkOutput("release_data", 64'(outData), 64'h0000000033333333);

        $display("[TB] drain");
        for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 1'b1);

        $display("[TB] counter saturation");
        pulseReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0100, 1'b1);
            checkOutput("sat_cnt2", 64'(satGrantCnt[5:4]), 64'(satExp[i]));
            checkOutput("sat_others", 64'({satGrantCnt[7:6], satGrantCnt[3:0]}), 64'd0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            in1 = $urandom; in2 = $urandom; in3 = $urandom; in4 = $urandom;
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
